// File: rtl/ucaspian_pkg.sv
// Shared definitions for the uCaspian synapse stage.
//   SYN_AW      synapse index width (synapse RAM depth 2^SYN_AW)
//   NEUR_AW     target neuron address width
//   WEIGHT_W    signed weight width
//   syn_entry_t one synapse RAM word: {target neuron, signed weight}
//   state_t     range-walker FSM states
package ucaspian_pkg;

  localparam int SYN_AW   = 12;
  localparam int NEUR_AW  = 8;
  localparam int WEIGHT_W = 8;

  typedef struct packed {
    logic        [NEUR_AW-1:0]  target;
    logic signed [WEIGHT_W-1:0] weight;
  } syn_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ucaspian_synapse_if.sv
// Handshake buses of the synapse stage.
//   syn_*  : inclusive synapse-index range from the axon stage (valid/ready)
//   dend_* : (target neuron, signed weight) charge events to the dendrite stage
// The synapse stage uses the slave modport; its environment uses master.
interface ucaspian_synapse_if;

  logic [ucaspian_pkg::SYN_AW-1:0]          syn_start;
  logic [ucaspian_pkg::SYN_AW-1:0]          syn_end;
  logic                                     syn_vld;
  logic                                     syn_rdy;

  logic [ucaspian_pkg::NEUR_AW-1:0]         dend_addr;
  logic signed [ucaspian_pkg::WEIGHT_W-1:0] dend_charge;
  logic                                     dend_vld;
  logic                                     dend_rdy;

  modport master (
    output syn_start, syn_end, syn_vld, dend_rdy,
    input  syn_rdy, dend_addr, dend_charge, dend_vld
  );

  modport slave (
    input  syn_start, syn_end, syn_vld, dend_rdy,
    output syn_rdy, dend_addr, dend_charge, dend_vld
  );

endinterface

// File: rtl/dp_ram_16x4096.sv
// 16-bit x 4096 simple dual-port RAM: one write port, one registered read port.
//   i_wr_en/i_wr_addr/i_wr_data : synchronous write
//   i_rd_en/i_rd_addr           : read request
//   o_rd_data                   : read data, valid the cycle after i_rd_en,
//                                 held while i_rd_en is low
module dp_ram_16x4096 (
  input  logic        clk,
  input  logic        i_wr_en,
  input  logic [11:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_en,
  input  logic [11:0] i_rd_addr,
  output logic [15:0] o_rd_data
);

  // NOTE: the storage array has no reset; a reset port would stop the tools
  // from mapping it onto block RAM. Clearing is done by an explicit sweep.
  logic [15:0] r_mem [4096];

  // NOTE: sequential state is always assigned with <= so every register
  // samples values from before the clock edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/ucaspian_syn_walker.sv
// Range walker: accepts an inclusive synapse-index range and issues one RAM
// read per cycle in which the output pipeline can advance.
//   i_enable/i_clear_config : gate acceptance of new ranges
//   i_syn_start/i_syn_end/i_syn_vld, o_syn_rdy : range handshake
//   i_advance               : pipeline is free to take another read
//   o_rd_en/o_rd_addr       : RAM read request
//   o_idle                  : FSM is in IDLE
module ucaspian_syn_walker
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_clear_config,
  input  logic [SYN_AW-1:0] i_syn_start,
  input  logic [SYN_AW-1:0] i_syn_end,
  input  logic              i_syn_vld,
  input  logic              i_advance,
  output logic              o_syn_rdy,
  output logic              o_rd_en,
  output logic [SYN_AW-1:0] o_rd_addr,
  output logic              o_idle
);

  state_t            r_state, w_state_nxt;
  logic [SYN_AW-1:0] r_idx, w_idx_nxt;
  // One bit wider than the index so a full 4096-entry range is representable.
  logic [SYN_AW:0]   r_remaining, w_remaining_nxt;
  logic [SYN_AW-1:0] w_span;

  assign w_span    = i_syn_end - i_syn_start;  // modulo 2^SYN_AW: handles wrap
  assign o_rd_addr = r_idx;
  assign o_idle    = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_remaining_nxt = r_remaining;
    o_syn_rdy       = 1'b0;
    o_rd_en         = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_syn_rdy = i_enable && !i_clear_config && !reset;
        if (o_syn_rdy && i_syn_vld) begin
          w_idx_nxt       = i_syn_start;
          w_remaining_nxt = {1'b0, w_span} + (SYN_AW+1)'(1);
          w_state_nxt     = RUN;
        end
      end
      RUN: begin
        if (i_advance) begin
          o_rd_en         = 1'b1;
          w_idx_nxt       = r_idx + SYN_AW'(1);
          w_remaining_nxt = r_remaining - (SYN_AW+1)'(1);
          if (r_remaining == (SYN_AW+1)'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/ucaspian_synapse.sv
// uCaspian synapse stage. Walks one synapse-index range per axon fire through
// the synapse RAM and emits a charge event for every non-zero-weight entry.
//   clk, reset            : clock, synchronous active-high reset
//   enable                : allow new ranges to be accepted
//   clear_config          : sweep-zero the synapse RAM while high
//   clear_done            : sweep finished (while clear_config is high)
//   config_addr/value/byte/enable : two-step RAM entry configuration
//   bus (slave)           : range input and charge-event output handshakes
//   step_done             : registered; block idle and empty
module ucaspian_synapse
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic [SYN_AW-1:0] config_addr,
  input  logic [11:0]       config_value,
  input  logic [1:0]        config_byte,
  input  logic              config_enable,
  ucaspian_synapse_if.slave bus,
  output logic              step_done
);

  logic              w_advance, w_rd_en, w_idle, w_syn_rdy;
  logic [SYN_AW-1:0] w_rd_addr;
  logic [15:0]       w_rd_data;
  syn_entry_t        w_rd_entry;

  logic              w_wr_en;
  logic [SYN_AW-1:0] w_wr_addr;
  syn_entry_t        w_wr_entry;

  logic [NEUR_AW-1:0] r_cfg_target;
  logic               r_cfg_pend;
  logic [SYN_AW-1:0]  r_cfg_addr;
  syn_entry_t         r_cfg_entry;

  logic [SYN_AW-1:0] r_clr_cnt;
  logic              r_clr_done;

  logic                       r_s1_vld, r_dend_vld, r_step_done;
  logic [NEUR_AW-1:0]         r_dend_addr;
  logic signed [WEIGHT_W-1:0] r_dend_charge;

  logic w_unused_cfg_hi;
  assign w_unused_cfg_hi = ^config_value[11:8];

  // The output register may only move when it is empty or being consumed.
  assign w_advance  = !(r_dend_vld && !bus.dend_rdy);
  assign w_rd_entry = syn_entry_t'(w_rd_data);

  ucaspian_syn_walker u_walker (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (enable),
    .i_clear_config (clear_config),
    .i_syn_start    (bus.syn_start),
    .i_syn_end      (bus.syn_end),
    .i_syn_vld      (bus.syn_vld),
    .i_advance      (w_advance),
    .o_syn_rdy      (w_syn_rdy),
    .o_rd_en        (w_rd_en),
    .o_rd_addr      (w_rd_addr),
    .o_idle         (w_idle)
  );

  dp_ram_16x4096 u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Config: byte 1 stages the target, byte 2 captures the full entry, which
  // is written on the following cycle unless a clear has taken the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_target <= '0;
      r_cfg_pend   <= 1'b0;
      r_cfg_addr   <= '0;
      r_cfg_entry  <= '0;
    end else begin
      r_cfg_pend <= 1'b0;
      if (config_enable && !clear_config) begin
        if (config_byte == 2'd1) r_cfg_target <= config_value[NEUR_AW-1:0];
        if (config_byte == 2'd2) begin
          r_cfg_pend  <= 1'b1;
          r_cfg_addr  <= config_addr;
          r_cfg_entry <= '{target: r_cfg_target, weight: config_value[WEIGHT_W-1:0]};
        end
      end
    end
  end

  // Clear sweep: one zero write per cycle until the last entry is written.
  always_ff @(posedge clk) begin
    if (reset || !clear_config) begin
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else if (!r_clr_done) begin
      r_clr_cnt <= r_clr_cnt + SYN_AW'(1);
      if (r_clr_cnt == {SYN_AW{1'b1}}) r_clr_done <= 1'b1;
    end
  end

  // Single write port: the clear sweep wins over a pending config write.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_addr  = r_clr_cnt;
    w_wr_entry = '0;
    if (clear_config) begin
      w_wr_en = !r_clr_done;
    end else if (r_cfg_pend) begin
      w_wr_en    = 1'b1;
      w_wr_addr  = r_cfg_addr;
      w_wr_entry = r_cfg_entry;
    end
  end

  // S1 tracks the read in flight; S2 is the output register. Zero-weight
  // entries are dropped here, so they cost a cycle but emit nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld      <= 1'b0;
      r_dend_vld    <= 1'b0;
      r_dend_addr   <= '0;
      r_dend_charge <= '0;
      r_step_done   <= 1'b0;
    end else begin
      if (w_advance) begin
        r_s1_vld   <= w_rd_en;
        r_dend_vld <= r_s1_vld && (w_rd_entry.weight != '0);
        if (r_s1_vld) begin
          r_dend_addr   <= w_rd_entry.target;
          r_dend_charge <= w_rd_entry.weight;
        end
      end
      r_step_done <= w_idle && !bus.syn_vld && !r_s1_vld && !r_dend_vld && !clear_config;
    end
  end

  assign bus.syn_rdy     = w_syn_rdy;
  assign bus.dend_vld    = r_dend_vld;
  assign bus.dend_addr   = r_dend_addr;
  assign bus.dend_charge = r_dend_charge;
  assign clear_done      = r_clr_done && clear_config;
  assign step_done       = r_step_done;

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Directed, table-driven bench for ucaspian_synapse. Inputs change 2ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_ucaspian_synapse;
  import ucaspian_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clear_config = 1'b0;
  logic        clear_done;
  logic [11:0] config_addr = '0;
  logic [11:0] config_value = '0;
  logic [1:0]  config_byte = '0;
  logic        config_enable = 1'b0;
  logic        step_done;

  ucaspian_synapse_if bus ();

  ucaspian_synapse dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear_config  (clear_config),
    .clear_done    (clear_done),
    .config_addr   (config_addr),
    .config_value  (config_value),
    .config_byte   (config_byte),
    .config_enable (config_enable),
    .bus           (bus),
    .step_done     (step_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] w;
    int         c;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk) begin
    if (bus.dend_vld && bus.dend_rdy) ev_q.push_back('{bus.dend_addr, bus.dend_charge, cyc});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic cfg_write(input logic [11:0] addr, input logic [7:0] tgt, input logic [7:0] w);
    step();
    config_enable = 1'b1; config_byte = 2'd1; config_value = {4'h0, tgt};
    step();
    config_byte = 2'd2; config_value = {4'h0, w}; config_addr = addr;
    step();
    config_enable = 1'b0; config_byte = 2'd0;
    step();
  endtask

  // Must be called just after a rising edge; returns 2ns after the accept edge
  // with syn_vld still high.
  task automatic accept_range(input logic [11:0] s, input logic [11:0] e, output int e0);
    bit ok = 0;
    bus.syn_start = s; bus.syn_end = e; bus.syn_vld = 1'b1;
    e0 = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.syn_rdy) begin
        ok = 1;
        step();
        e0 = cyc;
      end
    end
    if (!ok) check("range_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 60 && !ok; i++) begin
      if (step_done) ok = 1;
      else @(negedge clk);
    end
    check(name, {31'd0, ok}, 1);
    step();
  endtask

  typedef struct {
    logic [11:0]      s;
    logic [11:0]      e;
    int               n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  w;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int e0;
    int nsyn;
    ev_q.delete();
    accept_range(v.s, v.e, e0);
    bus.syn_vld = 1'b0;
    wait_idle({tag, "_step_done"});
    nsyn = int'((v.e - v.s) & 12'hFFF) + 1;
    check({tag, "_count"}, ev_q.size(), v.n);
    for (int i = 0; i < v.n && i < ev_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {24'd0, ev_q[i].a}, {24'd0, v.a[i]});
      check($sformatf("%s_w%0d", tag, i), {24'd0, ev_q[i].w}, {24'd0, v.w[i]});
    end
    if (ev_q.size() > 0 && v.n > 0) begin
      check({tag, "_first_lat"}, ev_q[0].c, e0 + 2);
      check({tag, "_last_lat"}, ev_q[ev_q.size()-1].c, e0 + 1 + nsyn);
    end
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    int e0, e0b, n_before;
    bit flag;

    bus.syn_start = '0; bus.syn_end = '0; bus.syn_vld = 1'b0; bus.dend_rdy = 1'b1;

    vecs[0] = '{12'd10,   12'd12,  3, {8'd0,  8'd9,  8'd7,  8'd5 }, {8'h00, 8'h01, 8'hFE, 8'h03}};
    vecs[1] = '{12'd4094, 12'd1,   4, {8'd23, 8'd22, 8'd21, 8'd20}, {8'hF9, 8'h06, 8'hFB, 8'h04}};
    vecs[2] = '{12'd100,  12'd101, 2, {8'd0,  8'd0,  8'd31, 8'd30}, {8'h00, 8'h00, 8'hF6, 8'h0A}};
    vecs[3] = '{12'd0,    12'd0,   1, {8'd0,  8'd0,  8'd0,  8'd22}, {8'h00, 8'h00, 8'h00, 8'h06}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_syn_rdy", {31'd0, bus.syn_rdy}, 0);
    check("rst_dend_vld", {31'd0, bus.dend_vld}, 0);
    check("rst_dend_addr", {24'd0, bus.dend_addr}, 0);
    check("rst_dend_charge", {24'd0, bus.dend_charge}, 0);
    check("rst_clear_done", {31'd0, clear_done}, 0);
    check("rst_step_done", {31'd0, step_done}, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("disabled_syn_rdy", {31'd0, bus.syn_rdy}, 0);
    step();
    enable = 1'b1;
    @(negedge clk);
    check("enabled_syn_rdy", {31'd0, bus.syn_rdy}, 1);
    check("idle_step_done", {31'd0, step_done}, 1);

    // Configure entries
    cfg_write(12'd10,   8'd5,  8'h03);
    cfg_write(12'd11,   8'd7,  8'hFE);
    cfg_write(12'd12,   8'd9,  8'h01);
    cfg_write(12'd4094, 8'd20, 8'h04);
    cfg_write(12'd4095, 8'd21, 8'hFB);
    cfg_write(12'd0,    8'd22, 8'h06);
    cfg_write(12'd1,    8'd23, 8'hF9);
    cfg_write(12'd100,  8'd30, 8'h0A);
    cfg_write(12'd101,  8'd31, 8'hF6);

    // Table-driven ranges
    foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Zero-weight entry is dropped
    cfg_write(12'd11, 8'd7, 8'h00);
    v = '{12'd10, 12'd12, 2, {8'd0, 8'd0, 8'd9, 8'd5}, {8'h00, 8'h00, 8'h01, 8'h03}};
    run_vec(v, "zero_w");
    cfg_write(12'd11, 8'd7, 8'hFE);

    // Backpressure: output held for 4 cycles, nothing lost or duplicated
    ev_q.delete();
    accept_range(12'd10, 12'd12, e0);
    bus.syn_vld = 1'b0;
    step();
    step();
    bus.dend_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_vld%0d", i), {31'd0, bus.dend_vld}, 1);
      check($sformatf("bp_addr%0d", i), {24'd0, bus.dend_addr}, 32'd5);
      check($sformatf("bp_w%0d", i), {24'd0, bus.dend_charge}, 32'h03);
    end
    step();
    bus.dend_rdy = 1'b1;
    wait_idle("bp_step_done");
    check("bp_count", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check("bp_addr_0", {24'd0, ev_q[0].a}, 32'd5);
      check("bp_addr_1", {24'd0, ev_q[1].a}, 32'd7);
      check("bp_w_1", {24'd0, ev_q[1].w}, 32'hFE);
      check("bp_addr_2", {24'd0, ev_q[2].a}, 32'd9);
    end

    // Back-to-back ranges with syn_vld held
    ev_q.delete();
    accept_range(12'd0, 12'd0, e0);
    accept_range(12'd100, 12'd101, e0b);
    bus.syn_vld = 1'b0;
    check("b2b_accept_edge", e0b, e0 + 2);
    wait_idle("b2b_step_done");
    check("b2b_count", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check("b2b_addr_0", {24'd0, ev_q[0].a}, 32'd22);
      check("b2b_addr_1", {24'd0, ev_q[1].a}, 32'd30);
      check("b2b_addr_2", {24'd0, ev_q[2].a}, 32'd31);
      check("b2b_w_2", {24'd0, ev_q[2].w}, 32'hF6);
    end

    // Reset mid-range abandons the range
    ev_q.delete();
    accept_range(12'd4094, 12'd1, e0);
    bus.syn_vld = 1'b0;
    step();
    step();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_dend_vld", {31'd0, bus.dend_vld}, 0);
    check("midrst_syn_rdy", {31'd0, bus.syn_rdy}, 0);
    step();
    reset = 1'b0;
    n_before = ev_q.size();
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.dend_vld) flag = 1;
    end
    check("midrst_no_events", {31'd0, flag}, 0);
    check("midrst_queue", ev_q.size(), n_before);
    check("midrst_step_done", {31'd0, step_done}, 1);

    // Clear sweep with a range pending throughout
    step();
    clear_config = 1'b1;
    bus.syn_start = 12'd0; bus.syn_end = 12'd3; bus.syn_vld = 1'b1;
    flag = 0;
    for (int i = 1; i <= 4097; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.syn_rdy) flag = 1;
      if (i == 4095) check("clr_done_early", {31'd0, clear_done}, 0);
      if (i == 4096) check("clr_done_4096", {31'd0, clear_done}, 1);
    end
    check("clr_syn_rdy_low", {31'd0, flag}, 0);
    check("clr_done_final", {31'd0, clear_done}, 1);
    check("clr_step_done", {31'd0, step_done}, 0);
    step();
    bus.syn_vld = 1'b0;
    step();
    clear_config = 1'b0;
    @(negedge clk);
    check("clr_done_drop", {31'd0, clear_done}, 0);
    step();

    // Cleared RAM emits nothing
    v = '{12'd0, 12'd3, 0, '0, '0};
    run_vec(v, "cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
